// File: rtl/pendulum_pkg.sv
// Shared definitions for the pendulum encoder front end and its consumers.
package pendulum_pkg;

  // Tracking states of the angle encoder.
  typedef enum logic [1:0] {
    UNCAL = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } enc_state_t;

  // Upright pendulum position; the balance controller regulates toward this.
  localparam logic [7:0] TARGET_ANGLE = 8'h80;

  // Result of comparing the previous and current filtered {A,B} pair.
  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_INC     = 2'd1,
    STEP_DEC     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  // 4x quadrature decode. Increment order is 00 -> 10 -> 11 -> 01 -> 00,
  // so the increment successor of {a,b} is {~b,a}.
  function automatic step_t decode_step(input logic [1:0] prev,
                                        input logic [1:0] curr);
    step_t s;
    if (prev == curr) begin
      s = STEP_NONE;
    end else if ((prev ^ curr) == 2'b11) begin
      s = STEP_ILLEGAL;
    end else if (curr == {~prev[0], prev[1]}) begin
      s = STEP_INC;
    end else begin
      s = STEP_DEC;
    end
    return s;
  endfunction

endpackage

// File: rtl/enc_pin_filter.sv
// Two-flop synchroniser followed by a consecutive-mismatch glitch filter
// for one raw encoder pin.
module enc_pin_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic filt
);

  // Counter value at which a persistent mismatch is accepted.
  localparam logic [3:0] CNT_LAST = 4'(FILTER_CYCLES - 1);

  logic       s1;
  logic       s2;
  logic [3:0] cnt;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has disagreed with filt long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= 1'b0;
      cnt  <= 4'd0;
    end else if (s2 == filt) begin
      cnt <= 4'd0;
    end else if (cnt == CNT_LAST) begin
      filt <= s2;
      cnt  <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/pendulum_angle_encoder.sv
// Quadrature encoder front end: filters A/B/index, decodes 4x into an
// up/down angle count, recalibrates on index and flags illegal transitions.
module pendulum_angle_encoder
  import pendulum_pkg::*;
#(
  parameter int                     ANGLE_WIDTH   = 8,
  parameter int                     FILTER_CYCLES = 4,
  parameter logic [ANGLE_WIDTH-1:0] INDEX_VALUE   = ANGLE_WIDTH'(TARGET_ANGLE)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enc_a,
  input  logic                   enc_b,
  input  logic                   enc_index,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   angle_valid,
  output logic                   calibrated,
  output logic                   fault,
  output logic                   direction
);

  // Bit 0 = A, bit 1 = B, bit 2 = index.
  logic [2:0] pins;
  logic [2:0] filt;

  assign pins = {enc_index, enc_b, enc_a};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pin
      enc_pin_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filter (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (pins[gi]),
        .filt   (filt[gi])
      );
    end
  endgenerate

  logic [1:0]             prev;
  logic                   index_prev;
  enc_state_t             state;
  enc_state_t             state_next;
  logic [ANGLE_WIDTH-1:0] angle_next;
  logic                   valid_next;
  logic                   direction_next;
  step_t                  step;
  logic                   index_rise;

  assign step       = decode_step(prev, {filt[0], filt[1]});
  assign index_rise = filt[2] & ~index_prev;

  // State, count and edge-detect history registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= 2'b00;
      index_prev  <= 1'b0;
      state       <= UNCAL;
      angle       <= INDEX_VALUE;
      angle_valid <= 1'b0;
      direction   <= 1'b0;
    end else begin
      prev        <= {filt[0], filt[1]};
      index_prev  <= filt[2];
      state       <= state_next;
      angle       <= angle_next;
      angle_valid <= valid_next;
      direction   <= direction_next;
    end
  end

  // Next state and count; an index edge overrides any step in the same cycle.
  always_comb begin
    state_next     = state;
    angle_next     = angle;
    valid_next     = 1'b0;
    direction_next = direction;
    if (index_rise) begin
      state_next = TRACK;
      angle_next = INDEX_VALUE;
      valid_next = 1'b1;
    end else begin
      case (state)
        UNCAL, TRACK: begin
          if (step == STEP_INC) begin
            angle_next     = angle + ANGLE_WIDTH'(1);
            direction_next = 1'b1;
            valid_next     = (state == TRACK);
          end else if (step == STEP_DEC) begin
            angle_next     = angle - ANGLE_WIDTH'(1);
            direction_next = 1'b0;
            valid_next     = (state == TRACK);
          end else if (step == STEP_ILLEGAL && state == TRACK) begin
            state_next = FAULT;
          end
        end
        FAULT: begin
          state_next = FAULT;
        end
        default: begin
          state_next = UNCAL;
        end
      endcase
    end
  end

  assign calibrated = (state == TRACK);
  assign fault      = (state == FAULT);

endmodule

// File: tb/tb_pendulum_angle_encoder.sv
// Directed bench for pendulum_angle_encoder with default parameters.
module tb_pendulum_angle_encoder;

  logic       clk;
  logic       reset_n;
  logic       enc_a;
  logic       enc_b;
  logic       enc_index;
  logic [7:0] angle;
  logic       angle_valid;
  logic       calibrated;
  logic       fault;
  logic       direction;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int s0 = 0;
  logic fault_seen = 1'b0;
  logic [7:0] exp_angle;
  int pos;
  logic [1:0] seq [4];

  pendulum_angle_encoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_index  (enc_index),
    .angle      (angle),
    .angle_valid(angle_valid),
    .calibrated (calibrated),
    .fault      (fault),
    .direction  (direction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n falling edges, counting strobes and watching for fault.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (angle_valid) strobes++;
      if (fault) fault_seen = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a new {a,b} pair and wait long enough for it to be counted.
  task automatic move(input logic [1:0] pair);
    {enc_a, enc_b} = pair;
    cyc(8);
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;

    // Reset with both channels high.
    reset_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_index = 1'b0; pos = 2;
    cyc(3);
    check("reset_angle", angle, 8'h80);
    check("reset_valid", angle_valid, 0);
    check("reset_calibrated", calibrated, 0);
    check("reset_fault", fault, 0);
    check("reset_direction", direction, 0);

    // Release; the simultaneous 00->11 settle must be absorbed in UNCAL.
    reset_n = 1'b1; fault_seen = 1'b0; strobes = 0;
    cyc(14);
    check("settle_fault_seen", fault_seen, 0);
    check("settle_strobes", strobes, 0);
    check("settle_angle", angle, 8'h80);
    check("settle_calibrated", calibrated, 0);

    // Three increments while uncalibrated: counted, no strobe.
    for (int i = 0; i < 3; i++) begin
      pos = (pos + 1) % 4;
      move(seq[pos]);
    end
    check("uncal_angle", angle, 8'h83);
    check("uncal_strobes", strobes, 0);
    check("uncal_direction", direction, 1);

    // Index pulse: reload lands 7 edges after sampling.
    enc_index = 1'b1;
    cyc(6);
    check("index_early_valid", angle_valid, 0);
    check("index_early_angle", angle, 8'h83);
    enc_index = 1'b0;
    cyc(1);
    check("index_valid", angle_valid, 1);
    check("index_angle", angle, 8'h80);
    check("index_calibrated", calibrated, 1);
    cyc(10);
    check("index_strobe_count", strobes, 1);

    // 128 increments wrap 80 -> 00, one strobe per step.
    exp_angle = 8'h80;
    for (int i = 0; i < 128; i++) begin
      pos = (pos + 1) % 4;
      s0 = strobes;
      move(seq[pos]);
      exp_angle = exp_angle + 8'd1;
      check("wrap_angle", angle, exp_angle);
      check("wrap_strobe", strobes - s0, 1);
    end
    check("wrap_final", angle, 8'h00);
    check("wrap_direction", direction, 1);

    // One decrement underflows to FF.
    pos = (pos + 3) % 4;
    s0 = strobes;
    move(seq[pos]);
    check("dec_angle", angle, 8'hFF);
    check("dec_direction", direction, 0);
    check("dec_strobe", strobes - s0, 1);

    // Three-clock glitch on A never reaches the filter.
    s0 = strobes;
    enc_a = ~enc_a;
    cyc(3);
    enc_a = ~enc_a;
    cyc(12);
    check("glitch_angle", angle, 8'hFF);
    check("glitch_strobe", strobes - s0, 0);

    // Recalibrate to 80 before exercising the fault path.
    s0 = strobes;
    enc_index = 1'b1;
    cyc(6);
    enc_index = 1'b0;
    cyc(10);
    check("recal_angle", angle, 8'h80);
    check("recal_strobe", strobes - s0, 1);

    // Both channels change at once: FAULT, angle holds.
    s0 = strobes;
    pos = (pos + 2) % 4;
    move(seq[pos]);
    check("fault_flag", fault, 1);
    check("fault_calibrated", calibrated, 0);
    check("fault_angle", angle, 8'h80);
    check("fault_strobe", strobes - s0, 0);

    // Steps while faulted are ignored.
    for (int i = 0; i < 2; i++) begin
      pos = (pos + 1) % 4;
      move(seq[pos]);
    end
    check("fault_hold_angle", angle, 8'h80);
    check("fault_hold_flag", fault, 1);
    check("fault_hold_direction", direction, 0);
    check("fault_hold_strobe", strobes - s0, 0);

    // Index recovers to TRACK.
    enc_index = 1'b1;
    cyc(6);
    enc_index = 1'b0;
    cyc(1);
    check("recover_valid", angle_valid, 1);
    cyc(10);
    check("recover_fault", fault, 0);
    check("recover_calibrated", calibrated, 1);
    check("recover_angle", angle, 8'h80);

    // One increment, then index and a decrement together: index wins.
    pos = (pos + 1) % 4;
    move(seq[pos]);
    check("pre_sim_angle", angle, 8'h81);
    check("pre_sim_direction", direction, 1);
    s0 = strobes;
    pos = (pos + 3) % 4;
    {enc_a, enc_b} = seq[pos];
    enc_index = 1'b1;
    cyc(6);
    enc_index = 1'b0;
    cyc(1);
    check("sim_valid", angle_valid, 1);
    check("sim_angle", angle, 8'h80);
    cyc(10);
    check("sim_strobe", strobes - s0, 1);
    check("sim_direction", direction, 1);
    check("sim_angle_hold", angle, 8'h80);

    // Reset asserted between clock edges clears everything at once.
    pos = (pos + 1) % 4;
    move(seq[pos]);
    check("pre_rst_angle", angle, 8'h81);
    pos = (pos + 1) % 4;
    {enc_a, enc_b} = seq[pos];
    cyc(3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_angle", angle, 8'h80);
    check("async_rst_valid", angle_valid, 0);
    check("async_rst_calibrated", calibrated, 0);
    check("async_rst_fault", fault, 0);
    check("async_rst_direction", direction, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(12);
    check("post_rst_calibrated", calibrated, 0);
    check("post_rst_fault", fault, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pendulum_angle_encoder.md
# pendulum_angle_encoder

Quadrature encoder front end that turns the pendulum shaft encoder's raw A/B/index pins into the 8-bit pendulum angle consumed by the cart balance controller, where 8'h80 is the upright target. It synchronises and glitch-filters the pins, decodes them 4x into an up/down position count, and recalibrates on the index mark. It also flags illegal transitions and publishes a one-cycle strobe on every angle update.

## Interface
- ANGLE_WIDTH, 8, width of the angle count; the count wraps modulo 2^ANGLE_WIDTH.
- FILTER_CYCLES, 4, consecutive mismatching cycles before a filtered pin changes; legal range 1..15.
- INDEX_VALUE, 8'h80, value loaded into the angle on the index rising edge (upright position).
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- enc_a  input  1  raw encoder channel A; asynchronous to clk
- enc_b  input  1  raw encoder channel B; asynchronous to clk
- enc_index  input  1  raw index mark, one pulse per revolution; asynchronous to clk
- angle  output  ANGLE_WIDTH  current pendulum angle count
- angle_valid  output  1  one-cycle strobe that `angle` changed while calibrated
- calibrated  output  1  high in state TRACK
- fault  output  1  high in state FAULT
- direction  output  1  direction of the last counted step: 1 = increment, 0 = decrement

## Operation
- Synchronisers:
  - Each pin passes through a 2-flop synchroniser (s1, s2).
  - All synchroniser flops reset to 0.
- Filters: one per pin.
  - Per-pin state is a filtered level `filt` and a mismatch counter.
  - Each cycle where s2 != filt, the counter increments. Each cycle where s2 == filt, the counter clears.
  - When the counter reaches FILTER_CYCLES-1 and s2 != filt, filt <= s2 and the counter clears.
  - filt and the counter reset to 0.
- Decoder:
  - Registered previous pair `prev` (reset 2'b00) compared with current pair {filt_a, filt_b}.
  - Increment sequence: 00→10→11→01→00.
  - Decrement sequence: the reverse of the increment sequence.
  - No change: no action.
  - Both bits changing in the same cycle is illegal.
- State machine, encoded in a shared package. Reset enters UNCAL.
  - UNCAL:
    - Legal steps update `angle` with no strobe.
    - Illegal steps are ignored, which absorbs post-reset settling.
    - Index rising edge → TRACK.
  - TRACK:
    - Legal steps update `angle` and pulse angle_valid.
    - Illegal step → FAULT; the count does not change.
  - FAULT:
    - `angle` holds and steps are ignored.
    - Index rising edge → TRACK, which reloads INDEX_VALUE.
- Index:
  - Rising edge of filtered index (filtered index was 0 last cycle, 1 now) loads `angle` with INDEX_VALUE.
  - The load pulses angle_valid in the cycle the state becomes or stays TRACK.
  - Index and a quadrature step in the same cycle: index wins and the step is discarded.
  - Index and an illegal step in the same cycle: index wins and the state goes to TRACK.
- Arithmetic:
  - Unsigned, modulo 2^ANGLE_WIDTH.
  - 8'hFF + 1 → 8'h00.
  - 8'h00 − 1 → 8'hFF.
  - No saturation.
- direction updates only on counted steps. It resets to 0.
- Reset values: angle = INDEX_VALUE, angle_valid = 0, calibrated = 0, fault = 0, direction = 0, state = UNCAL.
- Reset asserted mid-operation returns every register to its reset value immediately and asynchronously; calibration is lost.

## Timing
- Pin-to-angle latency, counting from the first clk edge that samples the new pin level into s1:
  - s2 changes at edge 2.
  - filt changes at edge FILTER_CYCLES+2.
  - `angle`, angle_valid, direction and state update at edge FILTER_CYCLES+3.
  - With default parameters this is 7 edges.
- All outputs are registered; there is no combinational path from pins to outputs.
- angle_valid is high for exactly one cycle per update and never two cycles for one step.
- Maximum trackable rate is one legal step per FILTER_CYCLES+1 clocks. Faster pin activity is rejected by the filter or flagged as illegal.
- Pulses shorter than FILTER_CYCLES clocks at s2 never reach filt.

## Structure
- Shared package pendulum_pkg:
  - state enum {UNCAL, TRACK, FAULT}
  - TARGET_ANGLE = 8'h80, the constant also used by the balance controller as INDEX_VALUE's default
  - quadrature step encodings.
- One sub-module, enc_pin_filter: the synchroniser plus glitch filter, parameterised by FILTER_CYCLES and instantiated three times.

## Test plan
- Reset settling: reset_n low with a=b=1, then release → UNCAL, angle=8'h80, fault=0 throughout, no angle_valid.
- Calibration:
  - After reset, run 3 increment steps, then pulse index for 6 clocks → angle=8'h83 and no strobes before the index.
  - Then angle=8'h80, calibrated=1, one strobe exactly 7 edges after index sampling.
- Count and wrap:
  - In TRACK, apply 128 increments from 8'h80 → angle=8'h00, then 1 decrement → 8'hFF.
  - Expect direction=0 and one strobe per step.
- Glitch rejection: 3-clock pulse on enc_a with FILTER_CYCLES=4 → angle unchanged, no strobe.
- Fault and recovery:
  - From TRACK at 8'h80, move both a and b simultaneously → fault=1, calibrated=0, angle holds 8'h80.
  - Then apply further steps → ignored.
  - Then index → TRACK, angle=8'h80, fault=0.
- Simultaneous events: align index rising and an increment to reach filt on the same edge → angle=INDEX_VALUE with a single strobe. Assert reset_n low mid-sequence → all outputs return to reset values asynchronously.
